// File: rtl/car_lane_sprite_pkg.sv
// Shared freeway-game constants: screen geometry, coordinate width,
// car state encoding and direction codes.
package car_lane_sprite_pkg;

  localparam int FW_SCREEN_W = 640;
  localparam int FW_SCREEN_H = 480;
  localparam int COORD_W     = 10;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    HIT = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/car_lane_sprite_if.sv
// Per-pixel and per-frame signals between the video pipeline and one car sprite.
interface car_lane_sprite_if;
  import car_lane_sprite_pkg::*;

  logic               frame_tick;
  logic               enable;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] column;
  logic               player_pix;
  logic               s;
  logic [COORD_W-1:0] x_pos;
  logic               collide;
  logic               hit_active;

  modport master (
    output frame_tick, enable, row, column, player_pix,
    input  s, x_pos, collide, hit_active
  );

  modport slave (
    input  frame_tick, enable, row, column, player_pix,
    output s, x_pos, collide, hit_active
  );

endinterface

// File: rtl/car_lane_sprite_box_hit.sv
// Strict-bounds rectangle test shared by the car and player sprites; compares
// one bit wider than the coordinates so origin+size never wraps.
module sprite_box_hit
  import car_lane_sprite_pkg::*;
#(
  parameter int W  = 30,
  parameter int H  = 30,
  parameter int CW = COORD_W
) (
  input  logic [CW-1:0] x0_i,
  input  logic [CW-1:0] y0_i,
  input  logic [CW-1:0] row_i,
  input  logic [CW-1:0] column_i,
  output logic          hit_o
);

  localparam logic [CW:0] W_X = (CW+1)'(W);
  localparam logic [CW:0] H_X = (CW+1)'(H);

  logic [CW:0] x0_w;
  logic [CW:0] y0_w;
  logic [CW:0] row_w;
  logic [CW:0] col_w;

  assign x0_w  = {1'b0, x0_i};
  assign y0_w  = {1'b0, y0_i};
  assign row_w = {1'b0, row_i};
  assign col_w = {1'b0, column_i};

  assign hit_o = (x0_w < col_w) && (col_w < (x0_w + W_X)) &&
                 (y0_w < row_w) && (row_w < (y0_w + H_X));

endmodule

// File: rtl/car_lane_sprite.sv
// One car moving along a fixed lane: steps every SPEED_DIV frames with edge
// wrap, reports its pixel coverage and freezes for HOLD_FRAMES after hitting the player.
module car_lane_sprite
  import car_lane_sprite_pkg::*;
#(
  parameter int SCREEN_W    = FW_SCREEN_W,
  parameter int CAR_W       = 30,
  parameter int CAR_H       = 30,
  parameter int LANE_Y      = 100,
  parameter int START_X     = 0,
  parameter bit DIR         = DIR_RIGHT,
  parameter int STEP        = 2,
  parameter int SPEED_DIV   = 1,
  parameter int HOLD_FRAMES = 60
) (
  input  logic              clk,
  input  logic              nrst,
  car_lane_sprite_if.slave  bus
);

  localparam int DIV_W  = (SPEED_DIV > 1)   ? $clog2(SPEED_DIV)   : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SPEED_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [COORD_W:0]   SCREEN_W_X = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0]   STEP_X     = (COORD_W+1)'(STEP);
  localparam logic [COORD_W-1:0] START_XQ   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] LANE_YQ    = COORD_W'(LANE_Y);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_HIT = 1'b1;

  logic [COORD_W-1:0] x_pos_q, x_pos_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [0:0]         state_q, state_d;
  logic               collide_q, collide_d;
  logic               hit_active_q, hit_active_d;

  logic               box_hit;
  logic               overlap;
  logic [COORD_W:0]   x_wide;
  logic [COORD_W-1:0] step_x;

  sprite_box_hit #(
    .W  (CAR_W),
    .H  (CAR_H),
    .CW (COORD_W)
  ) u_box (
    .x0_i     (x_pos_q),
    .y0_i     (LANE_YQ),
    .row_i    (bus.row),
    .column_i (bus.column),
    .hit_o    (box_hit)
  );

  assign overlap = box_hit & bus.player_pix;
  assign x_wide  = {1'b0, x_pos_q};

  // Next column after one step, wrapped into [0, SCREEN_W)
  always_comb begin
    step_x = x_pos_q;
    if (DIR == DIR_LEFT) begin
      if (x_wide < STEP_X) begin
        step_x = COORD_W'(x_wide + SCREEN_W_X - STEP_X);
      end else begin
        step_x = COORD_W'(x_wide - STEP_X);
      end
    end else begin
      if ((x_wide + STEP_X) >= SCREEN_W_X) begin
        step_x = COORD_W'(x_wide + STEP_X - SCREEN_W_X);
      end else begin
        step_x = COORD_W'(x_wide + STEP_X);
      end
    end
  end

  // RUN/HIT control; a collision takes priority over a same-cycle frame tick
  always_comb begin
    state_d    = state_q;
    x_pos_d    = x_pos_q;
    div_cnt_d  = div_cnt_q;
    hold_cnt_d = hold_cnt_q;
    collide_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (overlap) begin
          state_d   = ST_HIT;
          collide_d = 1'b1;
        end else if (bus.frame_tick && bus.enable) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            x_pos_d   = step_x;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q;
        end
      end
      ST_HIT: begin
        if (bus.frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d    = ST_RUN;
        hold_cnt_d = '0;
      end
    endcase
    hit_active_d = (state_d == ST_HIT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_pos_q      <= START_XQ;
      div_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      state_q      <= ST_RUN;
      collide_q    <= 1'b0;
      hit_active_q <= 1'b0;
    end else begin
      x_pos_q      <= x_pos_d;
      div_cnt_q    <= div_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      state_q      <= state_d;
      collide_q    <= collide_d;
      hit_active_q <= hit_active_d;
    end
  end

  assign bus.s          = box_hit;
  assign bus.x_pos      = x_pos_q;
  assign bus.collide    = collide_q;
  assign bus.hit_active = hit_active_q;

endmodule

// File: tb/tb_car_lane_sprite.sv
// Directed bench: five car instances with different parameter sets share one clock and reset.
module tb_car_lane_sprite;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;

  car_lane_sprite_if if_base ();
  car_lane_sprite_if if_wr ();
  car_lane_sprite_if if_wl ();
  car_lane_sprite_if if_div ();
  car_lane_sprite_if if_pos ();

  car_lane_sprite #(.START_X(0), .DIR(1'b0), .STEP(2), .SPEED_DIV(1), .HOLD_FRAMES(4))
    u_base (.clk(clk), .nrst(nrst), .bus(if_base));
  car_lane_sprite #(.START_X(638), .DIR(1'b0), .STEP(2), .SPEED_DIV(1), .HOLD_FRAMES(4))
    u_wr (.clk(clk), .nrst(nrst), .bus(if_wr));
  car_lane_sprite #(.START_X(1), .DIR(1'b1), .STEP(2), .SPEED_DIV(1), .HOLD_FRAMES(4))
    u_wl (.clk(clk), .nrst(nrst), .bus(if_wl));
  car_lane_sprite #(.START_X(0), .DIR(1'b0), .STEP(2), .SPEED_DIV(3), .HOLD_FRAMES(4))
    u_div (.clk(clk), .nrst(nrst), .bus(if_div));
  car_lane_sprite #(.START_X(100), .DIR(1'b0), .STEP(2), .SPEED_DIV(1), .HOLD_FRAMES(4))
    u_pos (.clk(clk), .nrst(nrst), .bus(if_pos));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame tick on the selected instance; returns on the negedge after the capturing edge
  task automatic tick(input int sel);
    @(negedge clk);
    case (sel)
      0: if_base.frame_tick = 1'b1;
      1: if_wr.frame_tick   = 1'b1;
      2: if_wl.frame_tick   = 1'b1;
      3: if_div.frame_tick  = 1'b1;
      default: if_pos.frame_tick = 1'b1;
    endcase
    @(negedge clk);
    if_base.frame_tick = 1'b0;
    if_wr.frame_tick   = 1'b0;
    if_wl.frame_tick   = 1'b0;
    if_div.frame_tick  = 1'b0;
    if_pos.frame_tick  = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    n_tests++; if (if_base.x_pos !== 10'd0)   begin n_fail++; $display("FAIL reset_base_x: got %0d expected 0", if_base.x_pos); end
    n_tests++; if (if_wr.x_pos !== 10'd638)   begin n_fail++; $display("FAIL reset_wr_x: got %0d expected 638", if_wr.x_pos); end
    n_tests++; if (if_wl.x_pos !== 10'd1)     begin n_fail++; $display("FAIL reset_wl_x: got %0d expected 1", if_wl.x_pos); end
    n_tests++; if (if_pos.x_pos !== 10'd100)  begin n_fail++; $display("FAIL reset_pos_x: got %0d expected 100", if_pos.x_pos); end
    n_tests++; if (if_pos.collide !== 1'b0)   begin n_fail++; $display("FAIL reset_collide: got %b expected 0", if_pos.collide); end
    n_tests++; if (if_pos.hit_active !== 1'b0) begin n_fail++; $display("FAIL reset_hit_active: got %b expected 0", if_pos.hit_active); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_step();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if_base.frame_tick = 1'b1;
      n_tests++;
      if (if_base.x_pos !== 10'(2 * (k - 1))) begin
        n_fail++; $display("FAIL step_before_edge_%0d: got %0d expected %0d", k, if_base.x_pos, 2 * (k - 1));
      end
      @(negedge clk);
      if_base.frame_tick = 1'b0;
      n_tests++;
      if (if_base.x_pos !== 10'(2 * k)) begin
        n_fail++; $display("FAIL step_after_edge_%0d: got %0d expected %0d", k, if_base.x_pos, 2 * k);
      end
    end
    @(negedge clk);
    n_tests++; if (if_base.x_pos !== 10'd6) begin n_fail++; $display("FAIL step_hold_no_tick: got %0d expected 6", if_base.x_pos); end
  endtask

  task automatic test_wrap();
    tick(1);
    n_tests++; if (if_wr.x_pos !== 10'd0)   begin n_fail++; $display("FAIL wrap_right: got %0d expected 0", if_wr.x_pos); end
    tick(2);
    n_tests++; if (if_wl.x_pos !== 10'd639) begin n_fail++; $display("FAIL wrap_left: got %0d expected 639", if_wl.x_pos); end
  endtask

  task automatic test_divider();
    int exp_x [6] = '{0, 0, 2, 2, 2, 4};
    for (int k = 0; k < 6; k++) begin
      tick(3);
      n_tests++;
      if (if_div.x_pos !== 10'(exp_x[k])) begin
        n_fail++; $display("FAIL div_tick_%0d: got %0d expected %0d", k + 1, if_div.x_pos, exp_x[k]);
      end
    end
    tick(3);
    tick(3);
    n_tests++; if (if_div.x_pos !== 10'd4) begin n_fail++; $display("FAIL div_two_more: got %0d expected 4", if_div.x_pos); end
    if_div.enable = 1'b0;
    for (int k = 0; k < 5; k++) tick(3);
    n_tests++; if (if_div.x_pos !== 10'd4) begin n_fail++; $display("FAIL div_disabled: got %0d expected 4", if_div.x_pos); end
    if_div.enable = 1'b1;
    tick(3);
    n_tests++; if (if_div.x_pos !== 10'd6) begin n_fail++; $display("FAIL div_reenabled: got %0d expected 6", if_div.x_pos); end
  endtask

  task automatic test_hitbox();
    int vr [7] = '{101, 101, 101, 100, 101, 129, 130};
    int vc [7] = '{101, 100, 130, 101, 129, 101, 101};
    logic ve [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if_pos.row    = 10'(vr[k]);
      if_pos.column = 10'(vc[k]);
      #1;
      n_tests++;
      if (if_pos.s !== ve[k]) begin
        n_fail++; $display("FAIL hitbox_r%0d_c%0d: got %b expected %b", vr[k], vc[k], if_pos.s, ve[k]);
      end
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    if_pos.row = 10'd101; if_pos.column = 10'd101; if_pos.player_pix = 1'b1;
    #1;
    n_tests++; if (if_pos.collide !== 1'b0) begin n_fail++; $display("FAIL coll_pre: got %b expected 0", if_pos.collide); end
    @(posedge clk); #1;
    n_tests++; if (if_pos.collide !== 1'b1)    begin n_fail++; $display("FAIL coll_pulse: got %b expected 1", if_pos.collide); end
    n_tests++; if (if_pos.hit_active !== 1'b1) begin n_fail++; $display("FAIL coll_hit_active: got %b expected 1", if_pos.hit_active); end
    @(posedge clk); #1;
    n_tests++; if (if_pos.collide !== 1'b0)    begin n_fail++; $display("FAIL coll_single_pulse: got %b expected 0", if_pos.collide); end
    n_tests++; if (if_pos.hit_active !== 1'b1) begin n_fail++; $display("FAIL coll_still_hit: got %b expected 1", if_pos.hit_active); end
    @(negedge clk);
    if_pos.player_pix = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(4);
      n_tests++; if (if_pos.x_pos !== 10'd100) begin n_fail++; $display("FAIL hold_x_%0d: got %0d expected 100", i, if_pos.x_pos); end
      n_tests++; if (if_pos.hit_active !== (i < 4)) begin n_fail++; $display("FAIL hold_active_%0d: got %b expected %b", i, if_pos.hit_active, (i < 4)); end
    end
    tick(4);
    n_tests++; if (if_pos.x_pos !== 10'd102) begin n_fail++; $display("FAIL resume_step: got %0d expected 102", if_pos.x_pos); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    if_pos.column = 10'd103; if_pos.player_pix = 1'b1; if_pos.frame_tick = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (if_pos.collide !== 1'b1) begin n_fail++; $display("FAIL simul_collide: got %b expected 1", if_pos.collide); end
    n_tests++; if (if_pos.x_pos !== 10'd102) begin n_fail++; $display("FAIL simul_no_step: got %0d expected 102", if_pos.x_pos); end
    @(negedge clk);
    if_pos.frame_tick = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(4);
      n_tests++; if (if_pos.hit_active !== (i < 4)) begin n_fail++; $display("FAIL overlap_hold_%0d: got %b expected %b", i, if_pos.hit_active, (i < 4)); end
      n_tests++; if (if_pos.collide !== 1'b0) begin n_fail++; $display("FAIL overlap_no_pulse_%0d: got %b expected 0", i, if_pos.collide); end
    end
    @(posedge clk); #1;
    n_tests++; if (if_pos.collide !== 1'b1) begin n_fail++; $display("FAIL recollide: got %b expected 1", if_pos.collide); end
    n_tests++; if (if_pos.x_pos !== 10'd102) begin n_fail++; $display("FAIL recollide_x: got %0d expected 102", if_pos.x_pos); end
    @(negedge clk);
    if_pos.player_pix = 1'b0;
    for (int i = 0; i < 4; i++) tick(4);
    n_tests++; if (if_pos.hit_active !== 1'b0) begin n_fail++; $display("FAIL second_hold_end: got %b expected 0", if_pos.hit_active); end
  endtask

  task automatic test_reset_mid_hit();
    @(negedge clk);
    if_pos.player_pix = 1'b1;
    @(posedge clk); #3;
    n_tests++; if (if_pos.hit_active !== 1'b1) begin n_fail++; $display("FAIL midhit_entered: got %b expected 1", if_pos.hit_active); end
    nrst = 1'b0;
    #1;
    n_tests++; if (if_pos.x_pos !== 10'd100)   begin n_fail++; $display("FAIL midhit_x: got %0d expected 100", if_pos.x_pos); end
    n_tests++; if (if_pos.hit_active !== 1'b0) begin n_fail++; $display("FAIL midhit_active: got %b expected 0", if_pos.hit_active); end
    n_tests++; if (if_pos.collide !== 1'b0)    begin n_fail++; $display("FAIL midhit_collide: got %b expected 0", if_pos.collide); end
    n_tests++; if (if_base.x_pos !== 10'd0)    begin n_fail++; $display("FAIL midhit_base_x: got %0d expected 0", if_base.x_pos); end
    @(negedge clk);
    if_pos.player_pix = 1'b0;
    nrst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nrst    = 1'b0;
    if_base.frame_tick = 1'b0; if_base.enable = 1'b1; if_base.row = '0; if_base.column = '0; if_base.player_pix = 1'b0;
    if_wr.frame_tick   = 1'b0; if_wr.enable   = 1'b1; if_wr.row   = '0; if_wr.column   = '0; if_wr.player_pix   = 1'b0;
    if_wl.frame_tick   = 1'b0; if_wl.enable   = 1'b1; if_wl.row   = '0; if_wl.column   = '0; if_wl.player_pix   = 1'b0;
    if_div.frame_tick  = 1'b0; if_div.enable  = 1'b1; if_div.row  = '0; if_div.column  = '0; if_div.player_pix  = 1'b0;
    if_pos.frame_tick  = 1'b0; if_pos.enable  = 1'b1; if_pos.row  = '0; if_pos.column  = '0; if_pos.player_pix  = 1'b0;

    test_reset();
    test_step();
    test_wrap();
    test_divider();
    test_hitbox();
    test_collision();
    test_simultaneous();
    test_reset_mid_hit();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
